// File: rtl/timer_dev.sv
// Memory-mapped 32-bit countdown timer (CTRL/PRESET/COUNT) raising irq on expiry, one-shot or auto-reload.
// Reads are combinational with zero wait states; writes take effect at the clock edge; there is no backpressure.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        hw_clr_en;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic auto_reload;

    assign ctrl_wr     = we && (addr == 2'd0);
    assign preset_wr   = we && (addr == 2'd1);
    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        hw_clr_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (count == 32'd0) begin
                    state_nxt = S_INT;
                    hw_clr_en = !auto_reload;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    state_nxt = en ? S_LOAD : S_IDLE;
                end else if (ctrl_wr) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= 32'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A bus write to CTRL overrides the hardware clear of En on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'd0;
        end else if (ctrl_wr && be[0]) begin
            ctrl <= wdata[3:0];
        end else if (hw_clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (preset_wr && be[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (addr)
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = (state == S_INT) && ctrl[3];

endmodule
